// File: rtl/pmp_pkg.sv
// pmp_pkg: shared types and constants for the PMP CSR bank.
//   pmp_cfg_t    - one pmpcfg byte (L, reserved, A, X, W, R)
//   A_*          - address-matching mode encodings
//   PMP_*_BASE   - default CSR addresses of pmpcfg0 / pmpaddr0
//   csr_state_e  - handshake FSM states
package pmp_pkg;

  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  localparam logic [11:0] PMP_CFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMP_ADDR_BASE = 12'h3B0;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    logic [1:0] a;
    logic       x;
    logic       w;
    logic       r;
  } pmp_cfg_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } csr_state_e;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// pmp_cfg_legalize: combinational WARL filter for one pmpcfg byte.
//   old_byte - currently stored cfg byte
//   new_byte - byte from the CSR write data
//   cfg_byte - value to store
// Build option: PMP_NA4_EN - when defined, A=NA4 is accepted as written;
// otherwise a write of A=NA4 keeps the previous A field.
module pmp_cfg_legalize
  import pmp_pkg::*;
(
  input  logic [7:0] old_byte,
  input  logic [7:0] new_byte,
  output logic [7:0] cfg_byte
);

  pmp_cfg_t old_c;
  pmp_cfg_t new_c;
  pmp_cfg_t res_c;

  assign old_c    = old_byte;
  assign new_c    = new_byte;
  assign cfg_byte = res_c;

  always_comb begin
    res_c      = new_c;
    res_c.rsvd = 2'b00;
    // R=0/W=1 is a reserved permission combination: keep the old permissions
    if (!new_c.r && new_c.w) begin
      res_c.x = old_c.x;
      res_c.w = old_c.w;
      res_c.r = old_c.r;
    end
`ifdef PMP_NA4_EN
`else
    if (new_c.a == A_NA4) begin
      res_c.a = old_c.a;
    end
`endif
    // a locked entry is frozen until reset
    if (old_c.l) begin
      res_c = old_c;
    end
  end

endmodule

// File: rtl/pmp_csr_bank.sv
// pmp_csr_bank: machine-mode PMP CSR register bank.
//   clk, rst_n            - clock, async active-low reset
//   csr_req_valid/ready   - request handshake
//   csr_we/addr/wdata     - request: write flag, CSR address, write data
//   csr_ack/rdata/err     - one-cycle response; err = address not in bank
//   pmp_cfg_o             - cfg byte i at [8i+7:8i]
//   pmp_addr_o            - pmpaddr i at [32i+31:32i]
// Build option: PMP_NA4_EN (see pmp_cfg_legalize).
//
// state | meaning
// IDLE  | ready for a request; writes commit on the accept edge
// RESP  | ack asserted with captured read data / error
module pmp_csr_bank
  import pmp_pkg::*;
#(
  parameter int          N_ENTRIES = 16,
  parameter logic [11:0] CFG_BASE  = PMP_CFG_BASE,
  parameter logic [11:0] ADDR_BASE = PMP_ADDR_BASE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      csr_req_valid,
  output logic                      csr_req_ready,
  input  logic                      csr_we,
  input  logic [11:0]               csr_addr,
  input  logic [31:0]               csr_wdata,
  output logic                      csr_ack,
  output logic [31:0]               csr_rdata,
  output logic                      csr_err,
  output logic [8*N_ENTRIES-1:0]    pmp_cfg_o,
  output logic [32*N_ENTRIES-1:0]   pmp_addr_o
);

  localparam logic [11:0] N_CFG_REGS  = 12'(N_ENTRIES / 4);
  localparam logic [11:0] N_ADDR_REGS = 12'(N_ENTRIES);

  csr_state_e           state_q, state_d;
  pmp_cfg_t             cfg_q     [N_ENTRIES];
  logic [31:0]          addr_q    [N_ENTRIES];
  logic [7:0]           cfg_legal [N_ENTRIES];
  logic [N_ENTRIES-1:0] cfg_wr, addr_wr, addr_lock;
  logic [11:0]          cfg_off, addr_off;
  logic                 cfg_hit, addr_hit, accept;
  logic [31:0]          rd_val, rdata_q;
  logic                 err_q;

  assign accept   = (state_q == IDLE) && csr_req_valid;
  // unsigned wrap makes addresses below a base fall out of range
  assign cfg_off  = csr_addr - CFG_BASE;
  assign addr_off = csr_addr - ADDR_BASE;
  assign cfg_hit  = cfg_off < N_CFG_REGS;
  assign addr_hit = addr_off < N_ADDR_REGS;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
    pmp_cfg_legalize u_legalize (
      .old_byte (cfg_q[i]),
      .new_byte (csr_wdata[8*(i%4) +: 8]),
      .cfg_byte (cfg_legal[i])
    );

    // a locked TOR entry also protects the pmpaddr below it (its base)
    if (i + 1 < N_ENTRIES) begin : g_tor
      assign addr_lock[i] = cfg_q[i].l || (cfg_q[i+1].l && (cfg_q[i+1].a == A_TOR));
    end else begin : g_last
      assign addr_lock[i] = cfg_q[i].l;
    end

    assign cfg_wr[i]  = accept && csr_we && cfg_hit && (cfg_off == 12'(i / 4));
    assign addr_wr[i] = accept && csr_we && addr_hit && (addr_off == 12'(i)) && !addr_lock[i];

    assign pmp_cfg_o[8*i +: 8]   = cfg_q[i];
    assign pmp_addr_o[32*i +: 32] = addr_q[i];
  end

  always_comb begin
    rd_val = '0;
    for (int k = 0; k < N_ENTRIES; k++) begin
      if (cfg_hit && (cfg_off == 12'(k / 4))) begin
        rd_val[8*(k%4) +: 8] = cfg_q[k];
      end
      if (addr_hit && (addr_off == 12'(k))) begin
        rd_val = addr_q[k];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    csr_req_ready = 1'b0;
    csr_ack       = 1'b0;
    case (state_q)
      IDLE: begin
        csr_req_ready = 1'b1;
        if (csr_req_valid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        csr_ack = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  assign csr_rdata = csr_ack ? rdata_q : '0;
  assign csr_err   = csr_ack & err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < N_ENTRIES; k++) begin
        cfg_q[k]  <= '0;
        addr_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        // read data is taken from the pre-write state
        rdata_q <= rd_val;
        err_q   <= !(cfg_hit || addr_hit);
      end
      for (int k = 0; k < N_ENTRIES; k++) begin
        if (cfg_wr[k]) begin
          cfg_q[k] <= cfg_legal[k];
        end
        if (addr_wr[k]) begin
          addr_q[k] <= csr_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_pmp_csr_bank.sv
module tb_pmp_csr_bank;

  localparam int N = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              csr_req_valid = 1'b0;
  logic              csr_req_ready;
  logic              csr_we = 1'b0;
  logic [11:0]       csr_addr = '0;
  logic [31:0]       csr_wdata = '0;
  logic              csr_ack;
  logic [31:0]       csr_rdata;
  logic              csr_err;
  logic [8*N-1:0]    pmp_cfg_o;
  logic [32*N-1:0]   pmp_addr_o;

  pmp_csr_bank #(.N_ENTRIES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_req_valid (csr_req_valid),
    .csr_req_ready (csr_req_ready),
    .csr_we        (csr_we),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_ack       (csr_ack),
    .csr_rdata     (csr_rdata),
    .csr_err       (csr_err),
    .pmp_cfg_o     (pmp_cfg_o),
    .pmp_addr_o    (pmp_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk;
    logic [15:0] cfg16;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_ack = -1;
  int   prev_ack = -1;
  logic ack_d = 1'b0;

`ifdef PMP_NA4_EN
  localparam logic [15:0] NA4_CFG = 16'h8913;
`else
  localparam logic [15:0] NA4_CFG = 16'h890B;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: pops one expectation per ack
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_ack) begin
        check("ack_single_cycle", {31'b0, ack_d}, 32'h0);
        check("ready_low_in_resp", {31'b0, csr_req_ready}, 32'h0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: got ack with empty queue at cycle %0d", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", csr_rdata, mon_e.rdata);
          check("err", {31'b0, csr_err}, {31'b0, mon_e.err});
          check("ack_latency", cyc, mon_e.acc_cyc);
          if (mon_e.chk) check("cfg_out", {16'h0, pmp_cfg_o[15:0]}, {16'h0, mon_e.cfg16});
        end
        prev_ack = last_ack;
        last_ack = cyc;
      end
      ack_d = csr_ack;
    end else begin
      ack_d = 1'b0;
    end
  end

  task automatic req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input logic chk, input logic [15:0] exp_cfg, input logic hold);
    int   n;
    exp_t e;
    @(negedge clk);
    csr_req_valid = 1'b1;
    csr_we        = we;
    csr_addr      = addr;
    csr_wdata     = wdata;
    n = 0;
    while (!csr_req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!csr_req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: ready stayed 0 for addr 0x%03h", addr);
      csr_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.chk     = chk;
    e.cfg16   = exp_cfg;
    e.acc_cyc = cyc;
    sb.push_back(e);
    if (!hold) csr_req_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp_rd, input logic exp_err);
    req(1'b0, addr, 32'h0, exp_rd, exp_err, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [31:0] old,
                    input logic chk, input logic [15:0] exp_cfg);
    req(1'b1, addr, data, old, 1'b0, chk, exp_cfg, 1'b0);
  endtask

  initial begin
    #12;
    check("rst_ready", {31'b0, csr_req_ready}, 32'h1);
    check("rst_ack", {31'b0, csr_ack}, 32'h0);
    check("rst_rdata", csr_rdata, 32'h0);
    check("rst_cfg", {31'b0, |pmp_cfg_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(12'h3A0, 32'h0, 1'b0);
    rd(12'h3B3, 32'h0, 1'b0);

    wr(12'h3A0, 32'h0000_0F0B, 32'h0, 1'b1, 16'h0F0B);
    rd(12'h3A0, 32'h0000_0F0B, 1'b0);

    // reserved bits and R=0/W=1 over an old R-only byte
    wr(12'h3A0, 32'h0000_0F01, 32'h0000_0F0B, 1'b1, 16'h0F01);
    wr(12'h3A0, 32'h0000_0F62, 32'h0000_0F01, 1'b1, 16'h0F01);
    rd(12'h3A0, 32'h0000_0F01, 1'b0);

    // decode boundaries
    rd(12'h3C0, 32'h0, 1'b1);
    req(1'b1, 12'h3C0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 16'h0F01, 1'b0);
    rd(12'h3A3, 32'h0, 1'b0);
    rd(12'h3A4, 32'h0, 1'b1);
    rd(12'h3BF, 32'h0, 1'b0);
    rd(12'h39F, 32'h0, 1'b1);

    // lock entry1 as TOR: pmpaddr0 and pmpaddr1 become read-only
    wr(12'h3A0, 32'h0000_8901, 32'h0000_0F01, 1'b1, 16'h8901);
    wr(12'h3B0, 32'h0000_1234, 32'h0, 1'b0, 16'h0);
    wr(12'h3B1, 32'h0000_5678, 32'h0, 1'b0, 16'h0);
    rd(12'h3B0, 32'h0, 1'b0);
    rd(12'h3B1, 32'h0, 1'b0);
    wr(12'h3A0, 32'h0000_0001, 32'h0000_8901, 1'b1, 16'h8901);
    rd(12'h3A0, 32'h0000_8901, 1'b0);

    wr(12'h3B2, 32'hDEAD_BEEF, 32'h0, 1'b0, 16'h0);
    check("addr2_out", pmp_addr_o[95:64], 32'hDEAD_BEEF);
    rd(12'h3B2, 32'hDEAD_BEEF, 1'b0);

    // NA4 WARL
    wr(12'h3A0, 32'h0000_000B, 32'h0000_8901, 1'b1, 16'h890B);
    wr(12'h3A0, 32'h0000_0013, 32'h0000_890B, 1'b1, NA4_CFG);
    rd(12'h3A0, {16'h0, NA4_CFG}, 1'b0);

    // back-to-back with valid held across RESP
    req(1'b0, 12'h3A0, 32'h0, {16'h0, NA4_CFG}, 1'b0, 1'b0, 16'h0, 1'b1);
    req(1'b0, 12'h3B2, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("b2b_ack_gap", last_ack - prev_ack, 32'd2);

    // reset while in RESP aborts the response
    @(negedge clk);
    csr_req_valid = 1'b1;
    csr_we        = 1'b1;
    csr_addr      = 12'h3B5;
    csr_wdata     = 32'h1234_5678;
    @(posedge clk);
    #1;
    csr_req_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check("abort_ack", {31'b0, csr_ack}, 32'h0);
    check("abort_err", {31'b0, csr_err}, 32'h0);
    check("abort_rdata", csr_rdata, 32'h0);
    check("abort_ready", {31'b0, csr_req_ready}, 32'h1);
    check("abort_cfg", {31'b0, |pmp_cfg_o}, 32'h0);
    check("abort_addr", {31'b0, |pmp_addr_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd(12'h3B5, 32'h0, 1'b0);
    rd(12'h3A0, 32'h0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d checks so far", checks);
    $fatal(1);
  end

endmodule

// File: doc/pmp_csr_bank.md
Name: pmp_csr_bank

Overview:
- Machine-mode CSR register bank for the PMP unit: the write/read side of the PMP configuration interface whose consumers are the per-entry address matchers (TOR/NA4/NAPOT).
- Accepts CSR read/write requests from the core over a valid/ack handshake.
- Enforces lock and WARL rules, and drives flattened pmpcfg/pmpaddr state to the matchers every cycle.

Parameters:
- N_ENTRIES, 16, number of PMP entries (multiple of 4, max 16).
- CFG_BASE, 12'h3A0, CSR address of pmpcfg0.
- ADDR_BASE, 12'h3B0, CSR address of pmpaddr0.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- csr_req_valid  input  1  request present.
- csr_req_ready  output  1  bank can accept a request.
- csr_we  input  1  1 = write, 0 = read.
- csr_addr  input  12  CSR address.
- csr_wdata  input  32  write data.
- csr_ack  output  1  one-cycle response strobe.
- csr_rdata  output  32  read data, valid with csr_ack.
- csr_err  output  1  with csr_ack: address not in bank.
- pmp_cfg_o  output  8*N_ENTRIES  cfg byte i at [8i+7:8i].
- pmp_addr_o  output  32*N_ENTRIES  pmpaddr i at [32i+31:32i].

Behaviour:
- Reset is asynchronous and active-low. All pmpcfg and pmpaddr registers clear to 0. csr_ack, csr_err and csr_rdata reset to 0; csr_req_ready resets to 1.
- FSM has two states, IDLE and RESP.
  - IDLE: csr_req_ready=1. A request is accepted when csr_req_valid=1; inputs are captured and the FSM moves to RESP.
  - RESP: csr_req_ready=0. csr_ack=1 for exactly one cycle with csr_rdata/csr_err, then the FSM returns to IDLE.
- Latency is 1 cycle from accept to ack. Back-to-back throughput is one request per 2 cycles.
- Register writes take effect on the accept edge, so pmp_*_o are updated in the same cycle csr_ack rises. Read data reflects state before any concurrent write.
- Address decode:
  - pmpcfgK at CFG_BASE+K, K < N_ENTRIES/4. It packs entries 4K..4K+3, bytes little-endian.
  - pmpaddrI at ADDR_BASE+I, I < N_ENTRIES.
  - Any other address: csr_err=1, csr_rdata=0, no state change.
- Cfg byte format: bit7 L, bits6:5 reserved, bits4:3 A (00 OFF, 01 TOR, 10 NA4, 11 NAPOT), bit2 X, bit1 W, bit0 R.
- Cfg write legalization, per byte, independently:
  - If the stored L=1, the byte is unchanged.
  - Bits 6:5 are always stored as 0.
  - If new R=0 and W=1 (reserved), the old R/W/X bits are retained; the other fields are written.
  - A write may set L; once set, L is cleared only by reset.
- pmpaddr I write is ignored if cfg[I].L=1.
- pmpaddr I write is also ignored if I+1 < N_ENTRIES and cfg[I+1].L=1 and cfg[I+1].A=TOR (locked TOR top-of-range protects its base).
- Ignored writes still ack with csr_err=0.
- pmpaddr stores all 32 bits, no granularity masking.
- Reset asserted mid-transaction aborts it: no ack is issued and state returns to IDLE with cleared registers.

Optional Feature:
- Macro: PMP_NA4_EN.
- Defined: A=10 (NA4) is stored as written.
- Undefined: a write with A=10 keeps the byte's previous A value (WARL); other fields are written normally. Reads never return A=10 after reset.

Decomposition:
- Package pmp_pkg holds:
  - pmp_cfg_t packed struct (l, rsvd[1:0], a[1:0], x, w, r).
  - A-field localparams A_OFF/A_TOR/A_NA4/A_NAPOT.
  - Default CSR base constants.
- One natural sub-module, pmp_cfg_legalize: combinational. Inputs are the old cfg byte and the new byte; output is the stored byte. It is instantiated once per entry.

Test Plan:
- Reset, then read pmpcfg0 (0x3A0) and pmpaddr3 (0x3B3) -> ack 1 cycle after accept, rdata=0, err=0; csr_req_ready=1 after reset.
- Write pmpcfg0=0x0000_0F0B, then read back -> rdata=0x0000_0F0B; entry0 cfg=0x0B, entry1 cfg=0x0F on pmp_cfg_o in the ack cycle.
- Write pmpcfg0 byte0=0x62 (reserved bits set, R=0/W=1) over old 0x01 -> stored 0x01. Illegal address 0x3C0 -> err=1, rdata=0.
- Write pmpcfg0 byte1=0x89 (L=1, A=TOR). Then write pmpaddr0=0x1234 and pmpaddr1=0x5678 -> both ignored, read 0. Then write pmpcfg0 byte1=0x00 -> stays 0x89.
- Issue a read while in RESP with csr_req_valid held -> not accepted until IDLE; second ack exactly 2 cycles after the first.
- With PMP_NA4_EN undefined, write cfg byte 0x13 over 0x0B -> stored 0x0B. With the macro defined -> stored 0x13. Also assert rst_n low in RESP -> no ack, all outputs 0.
